// File: rtl/nes_controller_reader.sv
// NES gamepad poller: latch/clock generation, serial shift-in, and an
// atomic per-frame button word with frame-valid and new-press pulses.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   nesData        serial pad data, active-low, asynchronous to clk
//   nesClock       registered shift clock to the pad
//   nesLatch       registered parallel-load latch to the pad
//   controllerData stable button state, 1 = pressed (also drives LEDs)
//   assemblyButton {8'h00, controllerData} for the CPU IO input
//   frameValid     one-cycle pulse when the outputs update
//   newPress       one-cycle per-button 0->1 pulses, with frameValid
module nes_controller_reader #(
    parameter int HALF_PERIOD = 300,
    parameter int POLL_TICKS  = 2750
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nesData,
    output logic        nesClock,
    output logic        nesLatch,
    output logic [7:0]  controllerData,
    output logic [15:0] assemblyButton,
    output logic        frameValid,
    output logic [7:0]  newPress
);

    localparam int TW = $clog2(HALF_PERIOD);
    localparam int PW = $clog2(POLL_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [PW-1:0]   poll_cnt;
    logic            latch_half;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic [1:0]      sync;
    logic            sync_data;

    assign tick           = (tick_cnt == TW'(HALF_PERIOD - 1));
    assign sync_data      = sync[1];
    assign assemblyButton = {8'h00, controllerData};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], nesData};
        end
    end

    // The single DONE cycle restarts the tick phase so the idle gap
    // is made of whole ticks counted from the end of the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick || state == DONE) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            poll_cnt       <= '0;
            latch_half     <= 1'b0;
            bit_idx        <= '0;
            shift          <= '0;
            nesClock       <= 1'b0;
            nesLatch       <= 1'b0;
            controllerData <= '0;
            frameValid     <= 1'b0;
            newPress       <= '0;
        end else begin
            frameValid <= 1'b0;
            newPress   <= '0;
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        if (poll_cnt == PW'(POLL_TICKS - 1)) begin
                            state      <= LATCH;
                            nesLatch   <= 1'b1;
                            latch_half <= 1'b0;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        if (latch_half) begin
                            state    <= LOW;
                            nesLatch <= 1'b0;
                            bit_idx  <= '0;
                        end else begin
                            latch_half <= 1'b1;
                        end
                    end
                end
                LOW: begin
                    if (tick) begin
                        shift[bit_idx] <= ~sync_data;
                        if (bit_idx == 3'd7) begin
                            state <= DONE;
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            state    <= HIGH;
                            nesClock <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (tick) begin
                        nesClock <= 1'b0;
                        state    <= LOW;
                    end
                end
                DONE: begin
                    controllerData <= shift;
                    newPress       <= shift & ~controllerData;
                    frameValid     <= 1'b1;
                    poll_cnt       <= '0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Bench for nes_controller_reader with a behavioural NES pad model
// and a queue of expected frame results.
module tb_nes_controller_reader;

    logic        clk;
    logic        reset;
    logic        nesData;
    logic        nesClock;
    logic        nesLatch;
    logic [7:0]  controllerData;
    logic [15:0] assemblyButton;
    logic        frameValid;
    logic [7:0]  newPress;

    int checks;
    int failures;

    typedef struct packed {
        logic [7:0] cd;
        logic [7:0] np;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] prev_model;

    logic [7:0] buttons;
    logic [7:0] pad;
    logic       pad_clk_q;
    logic       disconnected;
    logic       glitch;

    int cyc;
    int latch_run, latch_len;
    int last_rise, period;
    bit rise_seen;
    int pulses_cur, pulses_snap;
    int clk_run, clk_min, clk_max, min_snap, max_snap;
    int midchg;
    logic prev_latch, prev_clk;
    logic [7:0] prev_cd;

    nes_controller_reader #(
        .HALF_PERIOD(4),
        .POLL_TICKS(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .nesData(nesData),
        .nesClock(nesClock),
        .nesLatch(nesLatch),
        .controllerData(controllerData),
        .assemblyButton(assemblyButton),
        .frameValid(frameValid),
        .newPress(newPress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pad: parallel load while latched, shift toward bit0 on clock rise.
    always @(posedge clk) begin
        if (nesLatch) begin
            pad <= ~buttons;
        end else if (nesClock && !pad_clk_q) begin
            pad <= {1'b1, pad[7:1]};
        end
        pad_clk_q <= nesClock;
    end

    assign nesData = disconnected ? ~(glitch && nesClock) : pad[0];

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_latch <= nesLatch;
        prev_clk   <= nesClock;
        prev_cd    <= controllerData;
        if (!reset) begin
            latch_run  <= 0;
            rise_seen  <= 1'b0;
            pulses_cur <= 0;
            clk_run    <= 0;
        end else begin
            if (nesLatch) begin
                latch_run <= latch_run + 1;
            end else if (latch_run != 0) begin
                latch_len <= latch_run;
                latch_run <= 0;
            end
            if (nesLatch && !prev_latch) begin
                if (rise_seen) period <= cyc - last_rise;
                last_rise  <= cyc;
                rise_seen  <= 1'b1;
                pulses_cur <= 0;
                clk_min    <= 999;
                clk_max    <= 0;
            end
            if (nesClock && !prev_clk) pulses_cur <= pulses_cur + 1;
            if (nesClock) begin
                clk_run <= clk_run + 1;
            end else if (clk_run != 0) begin
                if (clk_run < clk_min) clk_min <= clk_run;
                if (clk_run > clk_max) clk_max <= clk_run;
                clk_run <= 0;
            end
            if (frameValid) begin
                pulses_snap <= pulses_cur;
                min_snap    <= clk_min;
                max_snap    <= clk_max;
            end
            if (controllerData != prev_cd && !frameValid) midchg <= midchg + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        exp_t e;
        e.cd = b;
        e.np = b & ~prev_model;
        prev_model = b;
        sb.push_back(e);
    endtask

    task automatic wait_frame(input string tag);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (frameValid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            failures++;
            $error("FAIL %s frame timeout", tag);
        end else if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s unexpected frame", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_cd"}, 32'(controllerData), 32'(e.cd));
            check({tag, "_np"}, 32'(newPress), 32'(e.np));
            check({tag, "_asm"}, 32'(assemblyButton), {24'h0, e.cd});
            @(posedge clk);
            #1;
            check({tag, "_fv_off"}, 32'(frameValid), 32'd0);
            check({tag, "_np_off"}, 32'(newPress), 32'd0);
        end
    endtask

    task automatic count_to_latch(input string tag);
        int  n;
        bit  got;
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (nesLatch) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            failures++;
            $error("FAIL %s latch timeout", tag);
        end else begin
            check(tag, 32'(n), 32'd40);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_latch"}, 32'(nesLatch), 32'd0);
        check({tag, "_clk"}, 32'(nesClock), 32'd0);
        check({tag, "_cd"}, 32'(controllerData), 32'd0);
        check({tag, "_fv"}, 32'(frameValid), 32'd0);
        check({tag, "_np"}, 32'(newPress), 32'd0);
    endtask

    initial begin
        int  rises;
        bit  got;
        checks       = 0;
        failures     = 0;
        prev_model   = 8'h00;
        cyc          = 0;
        midchg       = 0;
        latch_len    = 0;
        period       = 0;
        pulses_snap  = 0;
        min_snap     = 0;
        max_snap     = 0;
        clk_min      = 999;
        clk_max      = 0;
        pad          = 8'hFF;
        disconnected = 1'b0;
        glitch       = 1'b0;
        buttons      = 8'h81;
        reset        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        reset = 1'b1;
        count_to_latch("first_latch");

        // Abort mid-frame.
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        reset = 1'b1;
        count_to_latch("relatch");

        push_frame(8'h81);
        wait_frame("a_right");
        check("latch_len", 32'(latch_len), 32'd8);
        check("clk_pulses", 32'(pulses_snap), 32'd7);
        check("clk_hi_min", 32'(min_snap), 32'd4);
        check("clk_hi_max", 32'(max_snap), 32'd4);

        buttons = 8'h01;
        push_frame(8'h01);
        wait_frame("a_only");
        check("period", 32'(period), 32'd109);

        buttons = 8'h09;
        push_frame(8'h09);
        wait_frame("a_start");
        push_frame(8'h09);
        wait_frame("held");

        disconnected = 1'b1;
        glitch       = 1'b1;
        push_frame(8'h00);
        wait_frame("nopad1");
        push_frame(8'h00);
        wait_frame("nopad2");
        check("mid_frame_change", 32'(midchg), 32'd0);
        glitch       = 1'b0;
        disconnected = 1'b0;

        // Reset during HIGH of bit 4.
        buttons = 8'h81;
        got = 1'b0;
        rises = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (nesLatch) rises = 0;
            if (nesClock && !prev_clk) rises++;
            if (rises == 4) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            failures++;
            $error("FAIL high4 wait timeout");
        end else begin
            check("pre_rst_clk", 32'(nesClock), 32'd1);
            #1;
            reset = 1'b0;
            #1;
            check_reset_outputs("rst_high4");
            prev_model = 8'h00;
            repeat (2) @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            push_frame(8'h81);
            wait_frame("after_rst");
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
